// File: rtl/cheshire_uart_dbg_responder.sv
// rtl/cheshire_uart_dbg_responder.sv - UART debug preload responder (WRITE/READ/PING over a byte stream)
// Optional inter-byte timeout is enabled by defining CHESHIRE_UART_DBG_TIMEOUT_EN.
module cheshire_uart_dbg_responder #(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned TimeoutCycles = 1000000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    output logic                 rx_ready_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [63:0]          mem_wdata_o,
    output logic [7:0]           mem_be_o,
    input  logic                 mem_rvalid_i,
    input  logic [63:0]          mem_rdata_i,
    input  logic                 mem_err_i,
    output logic                 busy_o
);

    localparam int unsigned AddrBytes = AddrWidth / 8;
    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] OpRead  = 8'h52;
    localparam logic [7:0] OpPing  = 8'h50;
    localparam logic [7:0] Ack     = 8'h06;
    localparam logic [7:0] Nak     = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_WDATA,
        S_MREQ,
        S_MWAIT,
        S_RSEND,
        S_STATUS
    } state_e;

    state_e               state_q, state_d;
    logic                 is_write_q, is_write_d;
    logic                 err_q, err_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [7:0]           idx_q, idx_d;
    logic [63:0]          word_q, word_d;
    logic                 rx_hs;
    logic                 tx_hs;
    logic                 timeout_hit;

    assign rx_ready_o  = state_q inside {S_IDLE, S_ADDR, S_CNT, S_WDATA};
    assign rx_hs       = rx_valid_i & rx_ready_o;
    assign tx_valid_o  = (state_q == S_RSEND) || (state_q == S_STATUS);
    assign tx_data_o   = (state_q == S_RSEND) ? word_q[7:0] : (err_q ? Nak : Ack);
    assign tx_hs       = tx_valid_o & tx_ready_i;
    assign mem_req_o   = (state_q == S_MREQ);
    assign mem_we_o    = is_write_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = word_q;
    assign mem_be_o    = 8'hFF;
    assign busy_o      = (state_q != S_IDLE);

`ifdef CHESHIRE_UART_DBG_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

    logic [TmoW-1:0] tmo_q;
    logic            waiting_rx;

    assign waiting_rx  = state_q inside {S_ADDR, S_CNT, S_WDATA};
    assign timeout_hit = waiting_rx && !rx_hs && (tmo_q == TmoW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !waiting_rx || rx_hs) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TmoW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        word_d     = word_q;
        unique case (state_q)
            S_IDLE: begin
                if (rx_hs) begin
                    idx_d = '0;
                    if (rx_data_i == OpWrite || rx_data_i == OpRead) begin
                        is_write_d = (rx_data_i == OpWrite);
                        state_d    = S_ADDR;
                    end else begin
                        // PING acks, anything unrecognised naks
                        err_d   = (rx_data_i != OpPing);
                        state_d = S_STATUS;
                    end
                end
            end
            S_ADDR: begin
                if (rx_hs) begin
                    // little-endian: shifting in from the top leaves byte 0 at the bottom
                    addr_d = {rx_data_i, addr_q[AddrWidth-1:8]};
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == 8'(AddrBytes - 1)) begin
                        addr_d[2:0] = 3'b000;
                        idx_d       = '0;
                        state_d     = S_CNT;
                    end
                end
            end
            S_CNT: begin
                if (rx_hs) begin
                    cnt_d = {rx_data_i, cnt_q[15:8]};
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'd1) begin
                        idx_d = '0;
                        if (cnt_d == 16'd0) begin
                            state_d = S_STATUS;
                        end else if (is_write_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_MREQ;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (rx_hs) begin
                    word_d = {rx_data_i, word_q[63:8]};
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == 8'd7) begin
                        idx_d   = '0;
                        state_d = S_MREQ;
                    end
                end
            end
            S_MREQ: begin
                if (mem_gnt_i) begin
                    state_d = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (mem_rvalid_i) begin
                    err_d  = err_q | mem_err_i;
                    cnt_d  = cnt_q - 16'd1;
                    addr_d = addr_q + AddrWidth'(8);
                    if (!is_write_q) begin
                        word_d  = mem_rdata_i;
                        state_d = S_RSEND;
                    end else if (cnt_q == 16'd1) begin
                        state_d = S_STATUS;
                    end else begin
                        state_d = S_WDATA;
                    end
                end
            end
            S_RSEND: begin
                if (tx_hs) begin
                    word_d = {8'h00, word_q[63:8]};
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == 8'd7) begin
                        idx_d   = '0;
                        state_d = (cnt_q == 16'd0) ? S_STATUS : S_MREQ;
                    end
                end
            end
            S_STATUS: begin
                if (tx_hs) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_d = S_STATUS;
            err_d   = 1'b1;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: doc/cheshire_uart_dbg_responder.md
Name: cheshire_uart_dbg_responder

Overview:
- On-chip responder for the UART debug preload protocol: the SoC-side end of the host initiator that loads and reads memory over UART.
- Consumes a deserialized RX byte stream and parses WRITE, READ and PING commands.
- Issues 64-bit single-outstanding memory requests on a req/gnt/rvalid port and returns data and status bytes on a TX byte stream.
- Sits between the UART byte PHY and a system-bus master adapter; lets a host load an ELF with no boot software running.

Parameters:
- AddrWidth, 64: memory address width; multiple of 8; address sent as AddrWidth/8 bytes, little-endian.
- TimeoutCycles, 1000000: inter-byte timeout in clk_i cycles (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rx_valid_i  in  1  RX byte valid
- rx_data_i  in  8  RX byte
- rx_ready_o  out  1  RX byte accepted when valid & ready
- tx_valid_o  out  1  TX byte valid
- tx_data_o  out  8  TX byte
- tx_ready_i  in  1  TX sink ready
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  request granted
- mem_we_o  out  1  1 = write
- mem_addr_o  out  AddrWidth  word address; bits [2:0] always 0
- mem_wdata_o  out  64  write data
- mem_be_o  out  8  byte enables; constant 8'hFF
- mem_rvalid_i  in  1  response valid (read data or write ack)
- mem_rdata_i  in  64  read data
- mem_err_i  in  1  response error; sampled with rvalid
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_i high at a clk_i edge): state IDLE; err flag cleared; all counters cleared; tx_valid_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0; rx_ready_o=1.
- Reset mid-transaction: abort immediately, nothing transmitted. A pending granted response arriving after reset is ignored.
- Protocol: opcode byte, then address (AddrWidth/8 bytes LE), then count N (2 bytes LE, units of 64-bit words).
  - 0x57 WRITE: followed by N*8 data bytes LE.
  - 0x52 READ: responder returns N*8 data bytes LE.
  - 0x50 PING: no address or count.
  - Every command ends with one status byte: 0x06 ACK, or 0x15 NAK if any mem_err_i was seen during the command.
  - Unknown opcode: send 0x15, return to IDLE.
- Address handling: low 3 address bits are forced to 0. Address increments by 8 after each word, wrapping modulo 2^AddrWidth.
- N=0: no memory access; status 0x06 sent right after the count bytes.
- States: IDLE, ADDR, CNT, WDATA, MREQ, MWAIT, RSEND, STATUS.
  - IDLE -> ADDR on 0x57/0x52; -> STATUS on 0x50 (ACK) or unknown (NAK).
  - ADDR -> CNT after the last address byte; CNT -> STATUS if N=0, else WDATA (write) or MREQ (read).
  - WDATA -> MREQ after the 8th byte.
  - MREQ: hold mem_req_o with stable addr/we/wdata until mem_gnt_i; -> MWAIT.
  - MWAIT: on mem_rvalid_i, OR mem_err_i into the err flag and decrement N. Read -> RSEND with rdata latched. Write -> WDATA if N>0, else STATUS.
  - RSEND: send 8 bytes LSB first, then MREQ if N>0, else STATUS.
  - STATUS: send one byte, then IDLE and clear the err flag.
- rx_ready_o is 1 only in IDLE, ADDR, CNT and WDATA; a byte is consumed on rx_valid_i & rx_ready_o.
- TX: while tx_valid_o & !tx_ready_i, tx_data_o is held stable. The next byte may be presented in the cycle after a handshake (max 1 byte/cycle).
- Memory port: at most one outstanding request. mem_rvalid_i outside MWAIT is ignored. mem_gnt_i and mem_rvalid_i in the same cycle are not allowed (rvalid is at least 1 cycle after gnt).
- Latency: PING status tx_valid_o rises 1 cycle after the opcode handshake.

Optional Feature:
- Macro CHESHIRE_UART_DBG_TIMEOUT_EN.
- Defined:
  - A counter runs while in ADDR, CNT or WDATA with no RX handshake; it resets on each accepted byte.
  - On reaching TimeoutCycles: abort to STATUS, send 0x15, then IDLE.
  - Timeout is not applied during MREQ, MWAIT, RSEND or STATUS.
- Undefined: no counter; partial commands wait indefinitely.

Test Plan:
- PING: RX 0x50 -> TX exactly 0x06; no mem_req_o; busy_o low afterwards.
- WRITE 2 words at 0x8000_0000 (data 0x1122334455667788, 0xCAFEBABEDEADBEEF) -> two write requests at 0x80000000 and 0x80000008 with matching wdata and be=8'hFF; then TX 0x06.
- READ 1 word at 0x8000_0005: memory returns 0x0123456789ABCDEF -> request address 0x80000000; TX EF CD AB 89 67 45 23 01 06.
- READ with mem_err_i=1 on the 2nd of 2 words, tx_ready_i toggling every other cycle -> all 16 data bytes delivered stable and in order; final byte 0x15.
- Opcode 0x33 -> TX 0x15; next command PING -> 0x06. WRITE with N=0 -> 0x06, no memory access. Address 0xFFFF_FFFF_FFFF_FFF8 with N=2 -> second address 0x0.
- rst_i asserted in WDATA after 3 data bytes -> outputs at reset values the next cycle; a following PING returns 0x06. With the macro defined and TimeoutCycles=100: stall 100 cycles after the opcode -> TX 0x15.
